// File: rtl/sr_drv_pkg.sv
// Shared types, error codes and small helpers for the SR latch command driver.
package sr_drv_pkg;

    // Driver sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRIVE = 2'b01,
        DEAD  = 2'b10,
        CHECK = 2'b11
    } state_e;

    // Result codes reported on err_code.
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_INVALID = 2'b10;

    // Largest of three integers; sizes the shared phase counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Feedback is physically impossible for a healthy latch when both rails agree.
    function automatic logic fb_invalid(input logic q, input logic qbar);
        return (q == qbar);
    endfunction

    // Feedback agrees with the commanded latch state on both rails.
    function automatic logic fb_match(input logic q, input logic qbar, input logic target);
        return (q == target) && (qbar == !target);
    endfunction

endpackage : sr_drv_pkg

// File: rtl/sr_latch_driver_sync.sv
// Multi-flop synchroniser bringing the asynchronous latch Q/Qbar rails into the clk domain.
module sr_fb_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic q_async_i,
    input  logic qbar_async_i,
    output logic q_sync_o,
    output logic qbar_sync_o
);

    logic [STAGES-1:0] q_chain_q;
    logic [STAGES-1:0] q_chain_d;
    logic [STAGES-1:0] qbar_chain_q;
    logic [STAGES-1:0] qbar_chain_d;

    // New samples enter at bit 0 and walk towards the output bit.
    always_comb begin
        q_chain_d    = {q_chain_q[STAGES-2:0], q_async_i};
        qbar_chain_d = {qbar_chain_q[STAGES-2:0], qbar_async_i};
    end

    // Synchroniser flops, cleared while reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_chain_q    <= {STAGES{1'b0}};
            qbar_chain_q <= {STAGES{1'b0}};
        end else begin
            q_chain_q    <= q_chain_d;
            qbar_chain_q <= qbar_chain_d;
        end
    end

    assign q_sync_o    = q_chain_q[STAGES-1];
    assign qbar_sync_o = qbar_chain_q[STAGES-1];

endmodule : sr_fb_sync

// File: rtl/sr_latch_driver.sv
// Clocked command front-end for an asynchronous SR latch: accepts set/reset commands,
// drives a fixed-width non-overlapping S or R pulse, waits a dead time, then checks
// the synchronised feedback and reports done/err while tracking the expected state.
module sr_latch_driver
    import sr_drv_pkg::*;
#(
    parameter int PULSE_W     = 2,
    parameter int DEAD_T      = 1,
    parameter int TIMEOUT     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic       cmd_set,
    output logic       cmd_ready,
    output logic       S,
    output logic       R,
    input  logic       Q,
    input  logic       Qbar,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    output logic       exp_q
);

    localparam int CNT_MAX = max3(PULSE_W, DEAD_T, TIMEOUT);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Reload values: the counter runs down to zero, so a phase of N cycles loads N-1.
    localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] LD_DEAD  = CNT_W'((DEAD_T > 0) ? (DEAD_T - 1) : 0);
    localparam logic [CNT_W-1:0] LD_CHECK = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             target_q;
    logic             target_d;

    logic             s_q;
    logic             s_d;
    logic             r_q;
    logic             r_d;
    logic             busy_q;
    logic             busy_d;
    logic             done_q;
    logic             done_d;
    logic             err_q;
    logic             err_d;
    logic [1:0]       err_code_q;
    logic [1:0]       err_code_d;
    logic             exp_q_q;
    logic             exp_q_d;

    logic             q_sync_s;
    logic             qbar_sync_s;
    logic             accept_s;
    logic             cnt_zero_s;
    logic             chk_invalid_s;
    logic             chk_match_s;

    sr_fb_sync #(
        .STAGES (SYNC_STAGES)
    ) u_fb_sync (
        .clk          (clk),
        .rst_n        (rst_n),
        .q_async_i    (Q),
        .qbar_async_i (Qbar),
        .q_sync_o     (q_sync_s),
        .qbar_sync_o  (qbar_sync_s)
    );

    assign accept_s      = cmd_valid && (state_q == IDLE);
    assign cnt_zero_s    = (cnt_q == CNT_ZERO);
    assign chk_invalid_s = fb_invalid(q_sync_s, qbar_sync_s);
    assign chk_match_s   = fb_match(q_sync_s, qbar_sync_s, target_q);

    // State, shared phase counter and captured command target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= CNT_ZERO;
            target_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
        end
    end

    // Next-state sequencing; the counter is reloaded on every state entry.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d  = DRIVE;
                    cnt_d    = LD_PULSE;
                    target_d = cmd_set;
                end else begin
                    state_d  = IDLE;
                end
            end
            DRIVE: begin
                if (cnt_zero_s) begin
                    if (DEAD_T == 0) begin
                        state_d = CHECK;
                        cnt_d   = LD_CHECK;
                    end else begin
                        state_d = DEAD;
                        cnt_d   = LD_DEAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            DEAD: begin
                if (cnt_zero_s) begin
                    state_d = CHECK;
                    cnt_d   = LD_CHECK;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            CHECK: begin
                if (chk_invalid_s || chk_match_s || cnt_zero_s) begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Next values of the registered outputs; invalid feedback outranks a match.
    always_comb begin
        s_d        = 1'b0;
        r_d        = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q;
        err_code_d = err_code_q;
        exp_q_d    = exp_q_q;
        busy_d     = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    s_d        = cmd_set;
                    r_d        = !cmd_set;
                    err_d      = 1'b0;
                    err_code_d = ERR_NONE;
                end else begin
                    s_d = 1'b0;
                    r_d = 1'b0;
                end
            end
            DRIVE: begin
                if (cnt_zero_s) begin
                    s_d = 1'b0;
                    r_d = 1'b0;
                end else begin
                    s_d = target_q;
                    r_d = !target_q;
                end
            end
            DEAD: begin
                s_d = 1'b0;
                r_d = 1'b0;
            end
            CHECK: begin
                if (chk_invalid_s) begin
                    done_d     = 1'b1;
                    err_d      = 1'b1;
                    err_code_d = ERR_INVALID;
                end else if (chk_match_s) begin
                    done_d  = 1'b1;
                    exp_q_d = target_q;
                end else if (cnt_zero_s) begin
                    done_d     = 1'b1;
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end else begin
                    done_d = 1'b0;
                end
            end
            default: begin
                s_d = 1'b0;
                r_d = 1'b0;
            end
        endcase
    end

    // Output registers; asynchronous clear pulls S/R low the instant reset asserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            exp_q_q    <= 1'b0;
        end else begin
            s_q        <= s_d;
            r_q        <= r_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            exp_q_q    <= exp_q_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign S         = s_q;
    assign R         = r_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign exp_q     = exp_q_q;

endmodule : sr_latch_driver

// File: tb/tb_sr_latch_driver.sv
// Self-checking bench for sr_latch_driver: a behavioural SR latch drives the feedback,
// and a timing/outcome model predicts every command's pulses, done cycle and result.
module tb_sr_latch_driver;

    localparam int PW = 2;
    localparam int DT = 1;
    localparam int TO = 4;
    localparam int SY = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_set;
    logic       cmd_ready;
    logic       S;
    logic       R;
    logic       Q;
    logic       Qbar;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;
    logic       exp_q;

    // Behavioural latch plus an override used to inject stuck or invalid feedback.
    logic latch_q   = 1'b0;
    logic fb_forced = 1'b0;
    logic force_q   = 1'b0;
    logic force_qb  = 1'b0;

    int   tests     = 0;
    int   fails     = 0;
    int   cmd_idx   = 0;
    logic exp_model = 1'b0;

    always #5 clk = ~clk;

    always @(S or R) begin
        if (S && !R) latch_q = 1'b1;
        else if (R && !S) latch_q = 1'b0;
    end

    assign Q    = fb_forced ? force_q  : latch_q;
    assign Qbar = fb_forced ? force_qb : ~latch_q;

    sr_latch_driver #(
        .PULSE_W     (PW),
        .DEAD_T      (DT),
        .TIMEOUT     (TO),
        .SYNC_STAGES (SY)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_set   (cmd_set),
        .cmd_ready (cmd_ready),
        .S         (S),
        .R         (R),
        .Q         (Q),
        .Qbar      (Qbar),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code),
        .exp_q     (exp_q)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // S and R must never be high together.
    always @(negedge clk) begin
        check("no_overlap", {3'b000, S && R}, 4'h0);
    end

    // mode: 0 = real latch, 1 = stuck at fv (Q=fv, Qbar=!fv), 2 = invalid (Q=Qbar=fv).
    task automatic set_feedback(input int mode, input logic fv);
        if (mode == 1) begin
            fb_forced = 1'b1; force_q = fv; force_qb = !fv;
        end else if (mode == 2) begin
            fb_forced = 1'b1; force_q = fv; force_qb = fv;
        end else begin
            fb_forced = 1'b0;
        end
    endtask

    // Issues one command (called at a negedge) and checks it cycle by cycle until done.
    task automatic run_cmd(input logic t, input int mode, input logic fv,
                           input bit pre_presented, input bit keep_valid, input logic next_set);
        int         c0;
        int         vis;
        int         first;
        int         off;
        logic       new_exp;
        logic       e_err;
        logic [1:0] e_code;
        c0    = 1 + PW + DT;
        vis   = 1 + SY;
        first = (c0 > vis) ? c0 : vis;
        if (mode == 2) begin
            off = first + 1; new_exp = exp_model; e_err = 1'b1; e_code = 2'b10;
        end else if (mode == 1 && fv != t) begin
            off = c0 + TO;   new_exp = exp_model; e_err = 1'b1; e_code = 2'b01;
        end else begin
            off = first + 1; new_exp = t;         e_err = 1'b0; e_code = 2'b00;
        end
        cmd_idx++;
        set_feedback(mode, fv);
        if (!pre_presented) begin
            cmd_set   = t;
            cmd_valid = 1'b1;
        end
        check($sformatf("c%0d_ready_pre", cmd_idx), {3'b000, cmd_ready}, 4'h1);
        @(posedge clk);
        for (int k = 1; k <= off; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (keep_valid) cmd_set = next_set;
                else cmd_valid = 1'b0;
            end
            check($sformatf("c%0d_S_k%0d", cmd_idx, k), {3'b000, S}, {3'b000, t && (k <= PW)});
            check($sformatf("c%0d_R_k%0d", cmd_idx, k), {3'b000, R}, {3'b000, !t && (k <= PW)});
            check($sformatf("c%0d_done_k%0d", cmd_idx, k), {3'b000, done}, {3'b000, k == off});
            check($sformatf("c%0d_busy_k%0d", cmd_idx, k), {3'b000, busy}, {3'b000, k < off});
            check($sformatf("c%0d_rdy_k%0d", cmd_idx, k), {3'b000, cmd_ready}, {3'b000, k == off});
            check($sformatf("c%0d_err_k%0d", cmd_idx, k), {3'b000, err},
                  {3'b000, (k < off) ? 1'b0 : e_err});
            check($sformatf("c%0d_code_k%0d", cmd_idx, k), {2'b00, err_code},
                  {2'b00, (k < off) ? 2'b00 : e_code});
            check($sformatf("c%0d_expq_k%0d", cmd_idx, k), {3'b000, exp_q},
                  {3'b000, (k < off) ? exp_model : new_exp});
        end
        exp_model = new_exp;
        if (!keep_valid) begin
            @(negedge clk);
            check($sformatf("c%0d_done_after", cmd_idx), {3'b000, done}, 4'h0);
            check($sformatf("c%0d_idle_after", cmd_idx), {2'b00, cmd_ready, busy}, 4'h2);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b1;
        cmd_set   = 1'b1;

        // Reset held 3 cycles with a command presented: it must be ignored.
        repeat (3) @(negedge clk);
        check("rst_S", {3'b000, S}, 4'h0);
        check("rst_R", {3'b000, R}, 4'h0);
        check("rst_done", {3'b000, done}, 4'h0);
        check("rst_err", {3'b000, err}, 4'h0);
        check("rst_code", {2'b00, err_code}, 4'h0);
        check("rst_expq", {3'b000, exp_q}, 4'h0);
        check("rst_ready", {3'b000, cmd_ready}, 4'h1);
        check("rst_busy", {3'b000, busy}, 4'h0);
        cmd_valid = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        check("post_rst_busy", {3'b000, busy}, 4'h0);

        // Directed: set, reset, stuck-feedback timeout, recovery, invalid feedback.
        run_cmd(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_cmd(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_cmd(1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_cmd(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_cmd(1'b1, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        run_cmd(1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back: valid held high, second command taken on the done cycle's edge.
        run_cmd(1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_cmd(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Randomized commands with mixed feedback behaviour.
        for (int i = 0; i < 24; i++) begin
            int   sel;
            int   mode;
            logic t;
            logic fv;
            sel  = int'($urandom_range(0, 9));
            mode = (sel < 6) ? 0 : ((sel < 8) ? 1 : 2);
            t    = 1'($urandom_range(0, 1));
            fv   = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_cmd(t, mode, fv, 1'b0, 1'b0, 1'b0);
        end

        // Abort: reset during DRIVE drops S at once and yields no done pulse.
        set_feedback(0, 1'b0);
        cmd_set   = 1'b1;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("abort_S_before", {3'b000, S}, 4'h1);
        rst_n = 1'b0;
        #1;
        check("abort_S_async", {3'b000, S}, 4'h0);
        check("abort_R_async", {3'b000, R}, 4'h0);
        repeat (2) begin
            @(negedge clk);
            check("abort_done", {3'b000, done}, 4'h0);
            check("abort_busy", {3'b000, busy}, 4'h0);
            check("abort_expq", {3'b000, exp_q}, 4'h0);
        end
        rst_n     = 1'b1;
        exp_model = 1'b0;
        @(negedge clk);
        run_cmd(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_sr_latch_driver

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
- Clocked command front-end for the SR latch: accepts set/reset commands over a valid/ready handshake.
- Generates clean, non-overlapping, fixed-width S/R pulses, then waits a dead time.
- Synchronises and checks the latch's Q/Qbar feedback against the expected value.
- Reports done or error per command and tracks the expected latch state. Sits between synchronous control logic and the asynchronous latch.

Parameters:
PULSE_W, 2, number of cycles S or R is held high per command (>=1)
DEAD_T, 1, idle cycles with S=R=0 after the pulse before checking (>=0; 0 skips the DEAD state)
TIMEOUT, 4, maximum CHECK cycles to wait for matching feedback (>=1)
SYNC_STAGES, 2, flops in the Q/Qbar feedback synchroniser (>=2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_set  in  1  1 = set latch (pulse S), 0 = reset latch (pulse R); sampled on acceptance
cmd_ready  out  1  driver can accept a command
S  out  1  set drive to latch
R  out  1  reset drive to latch
Q  in  1  latch output (asynchronous)
Qbar  in  1  latch complementary output (asynchronous)
busy  out  1  command in progress
done  out  1  one-cycle pulse: command finished (success or error)
err  out  1  last command failed
err_code  out  2  00 none, 01 timeout, 10 invalid feedback (Q==Qbar)
exp_q  out  1  expected latch state after the last successful command

Behaviour:
- Reset: rst_n asynchronous, active-low. While low: S=0, R=0, done=0, err=0, err_code=00, exp_q=0, busy=0, state=IDLE, all counters 0, synchroniser flops cleared.
  - cmd_ready = (state==IDLE), so it reads 1 during reset; commands presented while rst_n=0 are ignored.
- Reset mid-operation: S and R drop to 0 immediately (asynchronously); the command is abandoned with no done pulse.
- FSM states: IDLE, DRIVE, DEAD, CHECK.
- IDLE:
  - cmd_ready=1, busy=0.
  - On clock edge N with cmd_valid&&cmd_ready: latch target=cmd_set, clear err/err_code, go to DRIVE.
- DRIVE:
  - S=target, R=!target, both registered.
  - High for exactly PULSE_W cycles, N+1..N+PULSE_W.
  - Then DEAD, or CHECK if DEAD_T=0.
- DEAD: S=R=0 for exactly DEAD_T cycles, then CHECK.
- CHECK:
  - S=R=0. Evaluates synchronised Q_s/Qbar_s each cycle, up to TIMEOUT cycles.
  - Q_s==target && Qbar_s==!target: exp_q<=target, done pulse next cycle, go to IDLE.
  - Q_s==Qbar_s (both 0 or both 1): err=1, err_code=10, done pulse, go to IDLE immediately; exp_q unchanged.
  - TIMEOUT cycles with neither outcome: err=1, err_code=01, done pulse, go to IDLE; exp_q unchanged.
  - If both conditions occur in one cycle, the invalid-feedback check wins.
- busy=1 in DRIVE, DEAD and CHECK. done is registered and high for exactly one cycle.
- err and err_code stay sticky until the next command is accepted.
- Invariant: S&&R is never 1 in any cycle.
- Commands are never queued; cmd_valid held through busy is accepted on the first IDLE cycle.
- Redundant commands (target==exp_q) are still fully driven and checked.
- A single shared down-counter, width $clog2(max(PULSE_W,DEAD_T,TIMEOUT)+1), is reloaded on each state entry.

Decomposition:
- Package sr_drv_pkg: state enum (IDLE, DRIVE, DEAD, CHECK), err_code localparams (ERR_NONE=2'b00, ERR_TIMEOUT=2'b01, ERR_INVALID=2'b10).
- Sub-module sr_fb_sync: SYNC_STAGES-deep flop chain for Q and Qbar, using the same clk/rst_n; instantiated once.

Test Plan:
(Defaults throughout; the bench's sr_latch model is connected to S/R/Q/Qbar. A concurrent assertion !(S&&R) is active in every test.)
1. Reset: rst_n=0 for 3 cycles -> S=R=0, done=0, err=0, err_code=00, exp_q=0, cmd_ready=1, busy=0.
2. Set: cmd_valid=1, cmd_set=1 accepted at edge N -> S=1 on cycles N+1..N+2, S=R=0 at N+3, CHECK from N+4; done pulses once by N+7; exp_q=1, err=0.
3. Reset after step 2: cmd_set=0 -> R=1 for exactly 2 cycles, S stays 0; done pulses; exp_q=0, err=0.
4. Stuck feedback: bench holds Q=0, Qbar=1 and issues a set -> after 4 CHECK cycles done pulses with err=1, err_code=01, exp_q=0. Next accepted command clears err.
5. Invalid feedback: force Q=Qbar=1 before CHECK -> on the first CHECK cycle done pulses with err=1, err_code=10; cmd_ready=1 on the following cycle.
6. Back-to-back and abort:
   - cmd_valid held high with cmd_set=1 then 0 -> second command accepted only on the first IDLE cycle after done; no overlap of S and R.
   - Drop rst_n during DRIVE -> S falls before the next clk edge; no done pulse; exp_q=0.
